thermometer_level_tracker: RTL
==============================

# thermometer_level_tracker

- Pipeline stage directly downstream of `thermometer_code_detector`.
- Consumes each input word (`codeIn`) together with the detector's combinational `isThermometer` verdict for that word.
- Converts each valid thermometer word to a binary fill level and orientation. On an invalid word it holds the last good level and counts the error.
- Runs a consecutive-hit lock state machine, and presents the results through a 1-deep valid/ready output register.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of `codeIn`; must match the detector.
- `ERR_CNT_WIDTH`, 8, width of the saturating error counter.
- `LOCK_GAIN`, 2, consecutive valid words needed to enter LOCKED (≥1).
- `LOCK_LOSS`, 3, consecutive invalid words needed to leave LOCKED (≥1).
- `LVL_W`, `$clog2(DATA_WIDTH+1)`, localparam; width of `level`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `din_valid` in 1: `codeIn` / `isThermometer` present a word.
- `din_ready` out 1: the stage can accept a word this cycle.
- `codeIn` in DATA_WIDTH: raw code word.
- `isThermometer` in 1: detector verdict for the same-cycle `codeIn`.
- `dout_valid` out 1: output beat available.
- `dout_ready` in 1: downstream accepts the beat.
- `level` out LVL_W: number of ones in the last valid word (0..DATA_WIDTH).
- `orient` out 1: 0 = ones fill from the LSB; 1 = ones fill from the MSB.
- `code_err` out 1: the word for this beat was invalid.
- `locked` out 1: FSM state after processing this beat's word.
- `err_count` out ERR_CNT_WIDTH: total invalid words accepted; saturates.

## Operation
- **Accept:** `acc = din_valid & din_ready`.
- **Ready:** `din_ready = ~dout_valid | dout_ready`. Full throughput, with a combinational ready path from downstream.
- **On `acc` with `isThermometer=1`:**
  - `level` = popcount(`codeIn`).
  - `orient` = `codeIn[DATA_WIDTH-1]` when level is in 1..DATA_WIDTH-1; otherwise 0.
  - `code_err` = 0.
  - The held level is updated.
- **On `acc` with `isThermometer=0`:**
  - `level` and `orient` repeat the last valid values (0/0 if there has been none since reset).
  - `code_err` = 1.
  - `err_count` increments, saturating at all-ones.
- **Trust of the verdict:** the block does not re-check validity; `isThermometer` is authoritative. All-zeros and all-ones are valid words.
- **Lock FSM (states UNLOCKED, LOCKED):** updates only on `acc`.
  - A run counter counts consecutive words of the kind that would cause a transition. It clears on a word of the opposite kind.
  - UNLOCKED → LOCKED when the valid run reaches `LOCK_GAIN`.
  - LOCKED → UNLOCKED when the invalid run reaches `LOCK_LOSS`.
  - The run counter clears on every transition.
- **Output register:**
  - Loads on `acc`.
  - `dout_valid` clears on `dout_ready` when there is no `acc` in the same cycle.
  - Push and pop in the same cycle: the new beat replaces the old one, and `dout_valid` stays 1.
- **Backpressure:** while `dout_valid & ~dout_ready`, all outputs are held stable and no internal state changes.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `dout_*` after edge N.
- Throughput is 1 word per cycle when `dout_ready=1`.
- **Reset values:**
  - Outputs: `dout_valid` 0, `level` 0, `orient` 0, `code_err` 0, `locked` 0, `err_count` 0.
  - Internal: FSM in UNLOCKED, run counter 0, held level/orient 0.
  - `din_ready` = 1 during and after reset.
- **Reset mid-operation:** a pending beat is dropped asynchronously; there is no partial update.
- **`err_count` saturation:** at all-ones it stays put; `code_err` still flags each further invalid beat.
- **Inputs while not ready:** `isThermometer` and `codeIn` are ignored when `din_valid=0` or `din_ready=0`.

## Structure
- **Package `thermo_pkg`:**
  - `lock_state_t` enum {UNLOCKED, LOCKED}.
  - Function `popcount` (parameterised by width via a caller loop).
  - Function `level_width(DATA_WIDTH)`.
- **Sub-module `thermo_lock_fsm`:**
  - Contains the FSM and run counter.
  - Inputs: `clk`, `reset`, `acc`, `word_ok`. Output: `locked`.
- **Top level:** holds the output register, held level, and error counter.

## Test plan
- **Lock gain:** reset, `LOCK_GAIN=2`, send `8'b00000111` twice with `isThermometer=1` → beats level 3 / orient 0 / locked 0, then level 3 / locked 1.
- **Invalid word:** while locked, send `8'b00000101` with `isThermometer=0` → level 3, `code_err` 1, `err_count` 1, locked 1.
  - Two more invalid words → locked drops to 0 on the third invalid beat; `err_count` 3.
- **MSB-filled word:** send `8'b11111000` valid → level 5, orient 1. Then send `8'hFF` → level 8, orient 0. Then send `8'h00` → level 0.
- **Backpressure:** hold `dout_ready=0` for 3 cycles while `din_valid=1` → first beat stable, `din_ready=0`, no word lost. Releasing ready delivers words in order.
- **Saturation:** `ERR_CNT_WIDTH=2`, 5 invalid words → `err_count` sequence 1, 2, 3, 3, 3.
- **Async reset:** assert `reset` mid-cycle while `dout_valid=1` → `dout_valid`, `locked` and `err_count` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermometer level tracker and its lock FSM.
package thermo_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    function automatic int level_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

    // One step of a bit count; the caller loops over the word, so any width works.
    function automatic int popcount(input int acc, input logic b);
        return acc + (b ? 1 : 0);
    endfunction

endpackage

// File: rtl/thermo_lock_fsm.sv
// Consecutive-hit lock detector: LOCK_GAIN good words in a row lock, LOCK_LOSS bad words in a row unlock.
module thermo_lock_fsm
    import thermo_pkg::*;
#(
    parameter int LOCK_GAIN = 2,
    parameter int LOCK_LOSS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic acc,
    input  logic word_ok,
    output logic locked
);

    localparam int RUN_MAX = (LOCK_GAIN > LOCK_LOSS) ? LOCK_GAIN : LOCK_LOSS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    lock_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             locked_q, locked_d;

    // The run counter only tracks words that push toward leaving the current state.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (acc) begin
            if (state_q == UNLOCKED) begin
                if (!word_ok) begin
                    run_d = '0;
                end else if (int'(run_q) + 1 >= LOCK_GAIN) begin
                    state_d = LOCKED;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                if (word_ok) begin
                    run_d = '0;
                end else if (int'(run_q) + 1 >= LOCK_LOSS) begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            run_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/thermometer_level_tracker.sv
// Converts detector-qualified thermometer words to a fill level/orientation, tracks errors
// and lock, and presents each result through a 1-deep valid/ready output register.
module thermometer_level_tracker
    import thermo_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int ERR_CNT_WIDTH = 8,
    parameter  int LOCK_GAIN     = 2,
    parameter  int LOCK_LOSS     = 3,
    localparam int LVL_W         = level_width(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [DATA_WIDTH-1:0]    codeIn,
    input  logic                     isThermometer,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [LVL_W-1:0]         level,
    output logic                     orient,
    output logic                     code_err,
    output logic                     locked,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    logic                     acc;
    logic [LVL_W-1:0]         pop_cnt;
    logic                     pop_orient;
    int                       cnt;

    logic                     dout_valid_q, dout_valid_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     orient_q, orient_d;
    logic                     code_err_q, code_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    // Valid/ready: a word is taken when din_valid & din_ready; the output register frees
    // up in the same cycle the downstream pops it, so ready passes through combinationally.
    assign din_ready = ~dout_valid_q | dout_ready;
    assign acc       = din_valid & din_ready;

    always_comb begin
        cnt = 0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt = popcount(cnt, codeIn[i]);
        end
        pop_cnt = LVL_W'(cnt);
    end

    // Empty and full words have no fill direction, so they report LSB-fill.
    assign pop_orient = (pop_cnt != '0 && pop_cnt != LVL_W'(DATA_WIDTH)) ?
                        codeIn[DATA_WIDTH-1] : 1'b0;

    // level_q/orient_q only load on valid words, so they double as the held last-good values.
    always_comb begin
        dout_valid_d = dout_valid_q;
        level_d      = level_q;
        orient_d     = orient_q;
        code_err_d   = code_err_q;
        err_count_d  = err_count_q;
        if (acc) begin
            dout_valid_d = 1'b1;
            code_err_d   = ~isThermometer;
            if (isThermometer) begin
                level_d  = pop_cnt;
                orient_d = pop_orient;
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_valid_q <= 1'b0;
            level_q      <= '0;
            orient_q     <= 1'b0;
            code_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            dout_valid_q <= dout_valid_d;
            level_q      <= level_d;
            orient_q     <= orient_d;
            code_err_q   <= code_err_d;
            err_count_q  <= err_count_d;
        end
    end

    thermo_lock_fsm #(
        .LOCK_GAIN (LOCK_GAIN),
        .LOCK_LOSS (LOCK_LOSS)
    ) u_lock_fsm (
        .clk     (clk),
        .reset   (reset),
        .acc     (acc),
        .word_ok (isThermometer),
        .locked  (locked)
    );

    assign dout_valid = dout_valid_q;
    assign level      = level_q;
    assign orient     = orient_q;
    assign code_err   = code_err_q;
    assign err_count  = err_count_q;

endmodule
